// File: rtl/cfifo_cpu_arbiter_pkg.sv
// Shared types for the FIFO CPU-port arbiter: FSM states, owner encoding,
// and the FIFO CPU address field layout (send/ctrl/cmd/addr).
package cfifo_cpu_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_LOCKED = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // FIFO CPU address encoding; the arbiter passes it through untouched.
  localparam int unsigned SEND_BIT = 12;
  localparam int unsigned CTRL_BIT = 11;
  localparam int unsigned CMD_MSB  = 10;
  localparam int unsigned CMD_LSB  = 9;
  localparam int unsigned ADDR_MSB = 8;

  // The requester that is not the current owner.
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/cfifo_rr_pick.sv
// 2-way round-robin selector.
//   req_a/req_b : pending requests
//   ptr         : preferred requester when both are pending
//   grant_a/b   : one-hot (or zero) winner, combinational
module cfifo_rr_pick
  import cfifo_cpu_arbiter_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_e ptr,
  output logic   grant_a,
  output logic   grant_b
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      grant_a = (ptr == OWN_A);
      grant_b = (ptr == OWN_B);
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/cfifo_cpu_arbiter.sv
// Shares the FIFO controller CPU port between the host bridge (A) and the
// packet processor (B). Single-beat accesses, round-robin with optional lock
// and a lock-hold timeout.
//   clk, reset (async, active-low)
//   a_*/b_*         : requester side (req/lock/wen/addr/din in; gnt/ack/dout out)
//   fifo_cpu_*      : controller CPU port
//   busy            : arbiter not idle
//   lock_timeout_err: sticky, set when a lock is force-released
module cfifo_cpu_arbiter
  import cfifo_cpu_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned LOCK_TIMEOUT = 255,
  parameter int unsigned TO_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_wen,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_wen,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic [ADDR_WIDTH-1:0] fifo_cpu_addr,
  output logic [DATA_WIDTH-1:0] fifo_cpu_din,
  output logic                  fifo_cpu_wen,
  input  logic [DATA_WIDTH-1:0] fifo_cpu_dout,
  output logic                  busy,
  output logic                  lock_timeout_err
);

  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                ptr_q, ptr_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;
  logic                  err_d;
  logic                  capture;
  logic                  pick_a, pick_b;
  logic                  cur_req, cur_lock;
  logic                  nxt_wen;
  logic [ADDR_WIDTH-1:0] nxt_addr, addr_d;
  logic [DATA_WIDTH-1:0] nxt_din, din_d;
  logic                  wen_d, a_gnt_d, b_gnt_d, a_ack_d, b_ack_d;

  cfifo_rr_pick u_pick (
    .req_a   (a_req),
    .req_b   (b_req),
    .ptr     (ptr_q),
    .grant_a (pick_a),
    .grant_b (pick_b)
  );

  // Current owner's hold signals, and the next owner's access payload.
  assign cur_req  = (owner_q == OWN_B) ? b_req  : a_req;
  assign cur_lock = (owner_q == OWN_B) ? b_lock : a_lock;
  assign nxt_wen  = (owner_d == OWN_B) ? b_wen  : a_wen;
  assign nxt_addr = (owner_d == OWN_B) ? b_addr : a_addr;
  assign nxt_din  = (owner_d == OWN_B) ? b_din  : a_din;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    lat_d   = lat_q;
    to_d    = to_q;
    err_d   = lock_timeout_err;
    capture = 1'b0;
    addr_d  = '0;
    din_d   = '0;
    wen_d   = 1'b0;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_a || pick_b) begin
          owner_d = pick_b ? OWN_B : OWN_A;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // fifo_cpu_wen holds the latched direction of the access in flight.
        to_d = '0;
        if (fifo_cpu_wen) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(RD_LATENCY)) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_DONE: begin
        if (cur_lock) begin
          state_d = ST_LOCKED;
          to_d    = '0;
        end else begin
          state_d = ST_IDLE;
          ptr_d   = other_owner(owner_q);
        end
      end
      ST_LOCKED: begin
        if (cur_req) begin
          state_d = ST_ISSUE;
          to_d    = '0;
        end else if (!cur_lock) begin
          state_d = ST_IDLE;
          ptr_d   = other_owner(owner_q);
          to_d    = '0;
        end else if ((to_q + TO_WIDTH'(1)) == TO_WIDTH'(LOCK_TIMEOUT)) begin
          state_d = ST_IDLE;
          ptr_d   = other_owner(owner_q);
          err_d   = 1'b1;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus drive: payload on entry to ISSUE, held through WAIT, zero otherwise.
    if (state_d == ST_ISSUE) begin
      addr_d = nxt_addr;
      din_d  = nxt_din;
      wen_d  = nxt_wen;
    end else if (state_d == ST_WAIT) begin
      addr_d = fifo_cpu_addr;
      din_d  = fifo_cpu_din;
    end

    a_gnt_d = (state_d != ST_IDLE) && (owner_d == OWN_A);
    b_gnt_d = (state_d != ST_IDLE) && (owner_d == OWN_B);
    a_ack_d = (state_d == ST_DONE) && (owner_d == OWN_A);
    b_ack_d = (state_d == ST_DONE) && (owner_d == OWN_B);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      owner_q          <= OWN_A;
      ptr_q            <= OWN_A;
      lat_q            <= '0;
      to_q             <= '0;
      lock_timeout_err <= 1'b0;
      fifo_cpu_addr    <= '0;
      fifo_cpu_din     <= '0;
      fifo_cpu_wen     <= 1'b0;
      a_gnt            <= 1'b0;
      b_gnt            <= 1'b0;
      a_ack            <= 1'b0;
      b_ack            <= 1'b0;
      a_dout           <= '0;
      b_dout           <= '0;
      busy             <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      ptr_q            <= ptr_d;
      lat_q            <= lat_d;
      to_q             <= to_d;
      lock_timeout_err <= err_d;
      fifo_cpu_addr    <= addr_d;
      fifo_cpu_din     <= din_d;
      fifo_cpu_wen     <= wen_d;
      a_gnt            <= a_gnt_d;
      b_gnt            <= b_gnt_d;
      a_ack            <= a_ack_d;
      b_ack            <= b_ack_d;
      busy             <= (state_d != ST_IDLE);
      if (capture && (owner_q == OWN_A)) a_dout <= fifo_cpu_dout;
      if (capture && (owner_q == OWN_B)) b_dout <= fifo_cpu_dout;
    end
  end

endmodule
